// File: rtl/render_pkg.sv
// Shared render-side types and constants: fixed-point unity, visible line count,
// matrix entry indices and the double-buffer controller state encoding.
package render_pkg;

  localparam int DATA_W   = 16;
  localparam int V_ACTIVE = 480;

  typedef logic signed [DATA_W-1:0] entry_t;
  typedef entry_t [15:0]            bank_t;

  localparam entry_t Q_ONE = 16'sh0020;

  typedef enum logic [1:0] {IDLE, LOAD, PENDING, SWAP} swap_state_t;

  localparam int IDX_D11 = 0;
  localparam int IDX_D12 = 1;
  localparam int IDX_D13 = 2;
  localparam int IDX_D14 = 3;
  localparam int IDX_D21 = 4;
  localparam int IDX_D22 = 5;
  localparam int IDX_D23 = 6;
  localparam int IDX_D24 = 7;
  localparam int IDX_D31 = 8;
  localparam int IDX_D32 = 9;
  localparam int IDX_D33 = 10;
  localparam int IDX_D34 = 11;
  localparam int IDX_D41 = 12;
  localparam int IDX_D42 = 13;
  localparam int IDX_D43 = 14;
  localparam int IDX_D44 = 15;

  function automatic bank_t identity_bank(input entry_t one);
    bank_t b;
    b          = '0;
    b[IDX_D11] = one;
    b[IDX_D22] = one;
    b[IDX_D33] = one;
    b[IDX_D44] = one;
    return b;
  endfunction

endpackage

// File: rtl/matrix_swap_ctrl_if.sv
// Matrix entry write channel: valid/ready beats carrying one entry each,
// with the final beat of an update flagged by wr_last.
interface matrix_swap_ctrl_if;
  import render_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_addr;
  entry_t     wr_data;
  logic       wr_last;
  logic [3:0] state_in;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_last, state_in,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_last, state_in,
    output wr_ready
  );

endinterface

// File: rtl/vblank_edge.sv
// Single-cycle pulse on the line where the VGA line counter first reaches the
// first non-visible line; a counter parked on that line yields one pulse only.
module vblank_edge #(
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 10
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [CNT_W-1:0] v_cnt,
  output logic             blank_edge
);

  localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] v_cnt_d;

  always_ff @(posedge pclk) begin
    if (rst) v_cnt_d <= '0;
    else     v_cnt_d <= v_cnt;
  end

  assign blank_edge = (v_cnt == V_EDGE) && (v_cnt_d != V_EDGE);

endmodule

// File: rtl/matrix_swap_ctrl.sv
// Double-buffered 4x4 transform matrix: entries land in a shadow bank and are
// copied to the active bank only at the start of vertical blanking.
module matrix_swap_ctrl
  import render_pkg::*;
#(
  parameter int     V_ACTIVE = render_pkg::V_ACTIVE,
  parameter entry_t Q_ONE    = render_pkg::Q_ONE
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [9:0]               v_cnt,
  matrix_swap_ctrl_if.slave        bus,
  output logic [3:0]               matrixState,
  output entry_t                   d11, d12, d13, d14,
  output entry_t                   d21, d22, d23, d24,
  output entry_t                   d31, d32, d33, d34,
  output entry_t                   d41, d42, d43, d44,
  output logic                     busy,
  output logic                     swap_done
);

  swap_state_t state;
  bank_t       shadow;
  bank_t       active;
  logic [3:0]  shadow_state;
  logic        blank_edge;
  logic        accept;

  vblank_edge #(
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (10)
  ) u_vblank_edge (
    .pclk       (CLK),
    .rst        (rst),
    .v_cnt      (v_cnt),
    .blank_edge (blank_edge)
  );

  assign accept = bus.wr_valid && bus.wr_ready;

  // wr_ready and busy are registered alongside the state so they never glitch
  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      bus.wr_ready <= 1'b1;
      busy         <= 1'b0;
      swap_done    <= 1'b0;
      shadow       <= identity_bank(Q_ONE);
      active       <= identity_bank(Q_ONE);
      shadow_state <= '0;
      matrixState  <= '0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            shadow[bus.wr_addr] <= bus.wr_data;
            if (bus.wr_last) begin
              shadow_state <= bus.state_in;
              state        <= PENDING;
              bus.wr_ready <= 1'b0;
              busy         <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        PENDING: begin
          if (blank_edge) state <= SWAP;
        end
        SWAP: begin
          active       <= shadow;
          matrixState  <= shadow_state;
          swap_done    <= 1'b1;
          state        <= IDLE;
          bus.wr_ready <= 1'b1;
          busy         <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.wr_ready <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  assign d11 = active[IDX_D11];
  assign d12 = active[IDX_D12];
  assign d13 = active[IDX_D13];
  assign d14 = active[IDX_D14];
  assign d21 = active[IDX_D21];
  assign d22 = active[IDX_D22];
  assign d23 = active[IDX_D23];
  assign d24 = active[IDX_D24];
  assign d31 = active[IDX_D31];
  assign d32 = active[IDX_D32];
  assign d33 = active[IDX_D33];
  assign d34 = active[IDX_D34];
  assign d41 = active[IDX_D41];
  assign d42 = active[IDX_D42];
  assign d43 = active[IDX_D43];
  assign d44 = active[IDX_D44];

endmodule

// File: doc/matrix_swap_ctrl.md
# matrix_swap_ctrl

Frame-synchronous double-buffer controller for the 4x4 transform matrix consumed by the render pipeline (normalization, line check, VGA colour output).
- Accepts matrix entry writes from the transform/host side into a shadow bank through a valid/ready handshake.
- Copies the shadow bank to the active bank, together with `matrixState`, only at the start of vertical blanking.
- The renderer therefore never sees a half-updated matrix within a frame.

## Interface
Parameters:
- `V_ACTIVE`, default 480: first non-visible line; a blank edge is `v_cnt` becoming equal to `V_ACTIVE`.
- `Q_ONE`, default 16'sh0020: fixed-point 1.0 in Q1.10.5, used for the identity matrix.

Ports:
- `CLK`  input  1  system clock; `v_cnt` and all handshakes are in this domain.
- `rst`  input  1  synchronous, active-high reset.
- `v_cnt`  input  10  current VGA line counter.
- `wr_valid`  input  1  entry write request.
- `wr_ready`  output  1  controller can accept an entry.
- `wr_addr`  input  4  entry index, row-major: 0 = d11, 1 = d12, …, 15 = d44.
- `wr_data`  input  16  signed Q1.10.5 entry value.
- `wr_last`  input  1  final entry of this update; commits the shadow bank.
- `state_in`  input  4  matrixState value to publish with this update, sampled on the accepted `wr_last` beat.
- `matrixState`  output  4  active matrix state.
- `d11`…`d44`  output  16 each  signed active matrix entries (16 ports).
- `busy`  output  1  high in `PENDING` or `SWAP`.
- `swap_done`  output  1  one-cycle pulse when the active bank has just been updated.

## Operation
- FSM states: `IDLE`, `LOAD`, `PENDING`, `SWAP`.
- `IDLE`:
  - `wr_ready`=1.
  - An accepted beat writes `shadow[wr_addr]`.
  - Go to `LOAD`, or to `PENDING` if `wr_last`=1.
- `LOAD`:
  - `wr_ready`=1; each accepted beat writes the shadow bank.
  - A repeated address overwrites; the last write wins.
  - Entries not written keep their previous shadow value, so partial updates are legal.
  - An accepted beat with `wr_last`=1 latches `state_in` into the shadow state and goes to `PENDING`.
- `PENDING`:
  - `wr_ready`=0.
  - Wait for a blank edge: registered `v_cnt_d != V_ACTIVE` and `v_cnt == V_ACTIVE`. Then go to `SWAP`.
- `SWAP`:
  - Lasts one cycle.
  - All 16 active entries take the shadow values and `matrixState` takes the shadow state.
  - Go to `IDLE`.
- `swap_done` is registered: it is high in the cycle after `SWAP`, coinciding with the new outputs being visible.
- Outputs:
  - `d11`…`d44` and `matrixState` change only on a `SWAP` cycle edge, never otherwise.
  - No arithmetic is performed; values pass through unmodified (16-bit signed, no saturation).
- Reset:
  - Active and shadow banks = identity: d11, d22, d33, d44 = `Q_ONE`; all others = 0.
  - `matrixState`=0, FSM=`IDLE`, `wr_ready`=1 after reset, `busy`=0, `swap_done`=0, `v_cnt_d`=0.
  - Reset mid-`LOAD` or in `PENDING` discards the update; shadow returns to identity.

## Timing
- Write-to-visible latency runs from the accepted `wr_last` to the first blank edge detected while in `PENDING`, +1 cycle for `SWAP`, +1 cycle register.
- Minimum latency is 2 cycles after the edge-detect cycle.
- If `wr_last` is accepted in the same cycle as a blank edge, the FSM is still in `LOAD` during that edge, so the swap waits for the next frame's edge (~1 frame).
- A blank edge while in `IDLE` or `LOAD` is ignored.
- `v_cnt` held at `V_ACTIVE` across many cycles produces exactly one edge.
- `wr_valid` while `wr_ready`=0 is not accepted; the requester must hold `wr_valid`, `wr_addr`, `wr_data`, `wr_last` and `state_in` stable until accepted.
- At most one swap per frame; back-to-back updates are accepted starting the cycle after `SWAP`.

## Structure
- Shared package `render_pkg`:
  - `Q_ONE`, `V_ACTIVE`.
  - FSM enum `swap_state_t {IDLE, LOAD, PENDING, SWAP}`.
  - Entry index constants `IDX_D11`…`IDX_D44`.
- One natural sub-module: `vblank_edge`. It holds the `v_cnt_d` register and the equality compare, and outputs a single-cycle `blank_edge` pulse. It is reusable by later frame-synchronous blocks.
- Banks: two 16x16 register arrays plus two 4-bit state registers; the active array maps directly to `d11`…`d44`.

## Test plan
- Reset: assert `rst` 2 cycles. Require d11=d22=d33=d44=0x0020, all others 0, `matrixState`=0, `wr_ready`=1, `busy`=0.
- Full update:
  - Stimulus: write addr 0..15 with data 0x0100+addr, `wr_last` on addr 15, `state_in`=4'h3.
  - Outputs stay unchanged until `v_cnt` steps 479→480.
  - Two cycles later, d11=0x0100 … d44=0x010F and `matrixState`=3, with `swap_done` high exactly 1 cycle.
- Partial update and overwrite:
  - Stimulus: from identity, write addr 5 = 0xFFE0 then addr 5 = 0x0040 with `wr_last`.
  - After swap, require d22=0x0040 and the other entries equal identity.
- Boundary: accept `wr_last` on the same cycle as the blank edge. Require no swap this frame, swap at the next 479→480 transition, and `wr_ready`=0 throughout.
- Backpressure: hold `wr_valid`=1 with a new addr/data while in `PENDING`. Require no shadow change until after `SWAP`, then acceptance in `IDLE`.
- Reset mid-operation: assert `rst` in `PENDING`, then produce a blank edge. Require no swap, outputs at identity, `swap_done`=0.
